// File: rtl/fcvt_sw_pipe_if.sv
// Handshake bundle for fcvt_sw_pipe: operand side (in_*, x) and result side (out_*, y).
// With FCVTSW_FLAGS_EN defined the bundle also carries the inexact flag nx.
interface fcvt_sw_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
`ifdef FCVTSW_FLAGS_EN
   logic        nx;
`endif

   modport slave (
      input  in_valid,
      input  x,
      input  out_ready,
      output in_ready,
      output out_valid,
      output y
`ifdef FCVTSW_FLAGS_EN
      , output nx
`endif
   );

   modport master (
      output in_valid,
      output x,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  y
`ifdef FCVTSW_FLAGS_EN
      , input nx
`endif
   );
endinterface

// File: rtl/fcvt_sw_pipe.sv
// fcvt_sw_pipe: 3-stage int32 -> binary32 converter (fcvt.s.w / fcvt.s.wu), round-to-nearest-even.
// Optional feature: define FCVTSW_FLAGS_EN to add the inexact flag output nx.
module fcvt_sw_pipe #(
   parameter int unsigned SIGNED = 1
) (
   input  logic          clk,
   input  logic          rstn,
   fcvt_sw_pipe_if.slave io_cvt
);

   function automatic logic [5:0] f_lzc(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            n = 6'(31 - i);
         end
      end
      return n;
   endfunction

   logic        w_adv;
   logic        w_s0;
   logic [31:0] w_mag0;
   logic        r_v1;
   logic        r_s1;
   logic [31:0] r_mag1;
   logic [5:0]  w_lz1;
   logic [31:0] w_nrm1;
   logic        r_v2;
   logic        r_s2;
   logic        r_z2;
   logic [5:0]  r_lz2;
   logic [31:0] r_nrm2;
   logic        w_g2;
   logic        w_st2;
   logic        w_up2;
   logic [24:0] w_rnd2;
   logic [30:0] w_bits2;
   logic [31:0] w_y2;
   logic        r_v3;
   logic [31:0] r_y;
`ifdef FCVTSW_FLAGS_EN
   logic        r_nx;
`endif

   assign w_adv            = !r_v3 || io_cvt.out_ready;
   assign io_cvt.in_ready  = w_adv;
   assign io_cvt.out_valid = r_v3;
   assign io_cvt.y         = r_y;
`ifdef FCVTSW_FLAGS_EN
   assign io_cvt.nx        = r_nx;
`endif

   // S1: sign and magnitude (negating 0x80000000 yields 2^31 as an unsigned value)
   always_comb begin
      if (SIGNED != 0) begin
         w_s0   = io_cvt.x[31];
         w_mag0 = io_cvt.x[31] ? (32'd0 - io_cvt.x) : io_cvt.x;
      end else begin
         w_s0   = 1'b0;
         w_mag0 = io_cvt.x;
      end
   end

   // S2: normalise so the leading one lands in bit 31
   always_comb begin
      w_lz1  = f_lzc(r_mag1);
      w_nrm1 = r_mag1 << w_lz1;
   end

   // S3: round and pack; the hidden bit and any carry out of the significand
   // add straight into the exponent field, hence the base of 157 rather than 158
   always_comb begin
      w_g2    = r_nrm2[7];
      w_st2   = |r_nrm2[6:0];
      w_up2   = w_g2 && (w_st2 || r_nrm2[8]);
      w_rnd2  = {1'b0, r_nrm2[31:8]} + {24'd0, w_up2};
      w_bits2 = {8'd157 - {2'b00, r_lz2}, 23'd0} + {6'd0, w_rnd2};
      if (r_z2) begin
         w_y2 = {r_s2, 31'd0};
      end else begin
         w_y2 = {r_s2, w_bits2};
      end
   end

   // Pipeline registers; the whole pipe advances or holds together
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_v1   <= 1'b0;
         r_s1   <= 1'b0;
         r_mag1 <= 32'd0;
         r_v2   <= 1'b0;
         r_s2   <= 1'b0;
         r_z2   <= 1'b0;
         r_lz2  <= 6'd0;
         r_nrm2 <= 32'd0;
         r_v3   <= 1'b0;
         r_y    <= 32'd0;
`ifdef FCVTSW_FLAGS_EN
         r_nx   <= 1'b0;
`endif
      end else if (w_adv) begin
         r_v1 <= io_cvt.in_valid;
         if (io_cvt.in_valid) begin
            r_s1   <= w_s0;
            r_mag1 <= w_mag0;
         end
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2   <= r_s1;
            r_z2   <= (r_mag1 == 32'd0);
            r_lz2  <= w_lz1;
            r_nrm2 <= w_nrm1;
         end
         r_v3 <= r_v2;
         if (r_v2) begin
            r_y  <= w_y2;
`ifdef FCVTSW_FLAGS_EN
            r_nx <= w_g2 || w_st2;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fcvt_sw_pipe.sv
// Self-checking bench for fcvt_sw_pipe: a signed and an unsigned instance share stimulus and are
// scored against an arithmetic reference conversion; nx is checked when FCVTSW_FLAGS_EN is defined.
module tb_fcvt_sw_pipe;
   logic clk;
   logic rstn;
   int   n_checks;
   int   n_pass;
   int   n_fail;

   logic [31:0] q_ys[$];
   logic [31:0] q_yu[$];
   logic        q_nxs[$];
   logic        q_nxu[$];

   fcvt_sw_pipe_if ifs();
   fcvt_sw_pipe_if ifu();

   fcvt_sw_pipe #(.SIGNED(1)) u_dut_s (.clk(clk), .rstn(rstn), .io_cvt(ifs));
   fcvt_sw_pipe #(.SIGNED(0)) u_dut_u (.clk(clk), .rstn(rstn), .io_cvt(ifu));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer value rounded to 24 significant bits, ties to even.
   // Returns {inexact, float bits}.
   function automatic logic [32:0] ref_cvt(input logic [31:0] xv, input bit sgn);
      longint mag, q, rem, half;
      int     p, sh;
      logic   s;
      s   = sgn && xv[31];
      mag = s ? -longint'($signed(xv)) : longint'({32'd0, xv});
      if (mag == 0) return 33'd0;
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      rem = 0;
      if (p <= 23) begin
         q = mag << (23 - p);
      end else begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            p++;
         end
      end
      return {rem != 0, s, 8'(127 + p), q[22:0]};
   endfunction

   task automatic set_inputs(input logic v, input logic [31:0] xv, input logic ordy);
      ifs.in_valid = v;  ifs.x = xv;  ifs.out_ready = ordy;
      ifu.in_valid = v;  ifu.x = xv;  ifu.out_ready = ordy;
   endtask

   // One clock: drive at the falling edge, score the transfers the next rising edge will make.
   task automatic step(input logic v, input logic [31:0] xv, input logic ordy,
                       input logic gold_en, input logic [31:0] gs, input logic [31:0] gu,
                       output logic acc);
      logic [32:0] rs, ru;
      @(negedge clk);
      set_inputs(v, xv, ordy);
      #1;
      if (ifs.out_valid && ordy) begin
         if (q_ys.size() == 0) chk("spurious_s", {31'd0, ifs.out_valid}, 32'd0);
         else begin
            chk("y_s", ifs.y, q_ys.pop_front());
`ifdef FCVTSW_FLAGS_EN
            chk("nx_s", {31'd0, ifs.nx}, {31'd0, q_nxs.pop_front()});
`endif
         end
      end
      if (ifu.out_valid && ordy) begin
         if (q_yu.size() == 0) chk("spurious_u", {31'd0, ifu.out_valid}, 32'd0);
         else begin
            chk("y_u", ifu.y, q_yu.pop_front());
`ifdef FCVTSW_FLAGS_EN
            chk("nx_u", {31'd0, ifu.nx}, {31'd0, q_nxu.pop_front()});
`endif
         end
      end
      acc = v && ifs.in_ready;
      if (acc) begin
         rs = ref_cvt(xv, 1'b1);
         ru = ref_cvt(xv, 1'b0);
         q_ys.push_back(gold_en ? gs : rs[31:0]);
         q_yu.push_back(gold_en ? gu : ru[31:0]);
         q_nxs.push_back(rs[32]);
         q_nxu.push_back(ru[32]);
      end
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int i = 0; i < 40 && (q_ys.size() != 0 || q_yu.size() != 0); i++)
         step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, acc);
      chk({tag, "_drain_s"}, 32'(q_ys.size()), 32'd0);
      chk({tag, "_drain_u"}, 32'(q_yu.size()), 32'd0);
   endtask

   logic [31:0] dir_x[8]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h01FFFFFF};
   logic [31:0] dir_ys[8] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'hCF000000,
                              32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4C000000};
   logic [31:0] dir_yu[8] = '{32'h00000000, 32'h3F800000, 32'h4F800000, 32'h4F000000,
                              32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4C000000};
   logic [31:0] bp_y[5]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

   initial begin
      logic        acc;
      logic [31:0] xv;
      logic [31:0] r;
      int          idx;
      logic        ordy;
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      set_inputs(1'b0, 32'd0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ov_s", {31'd0, ifs.out_valid}, 32'd0);
      chk("rst_ov_u", {31'd0, ifu.out_valid}, 32'd0);
      chk("rst_y_s", ifs.y, 32'd0);
      chk("rst_y_u", ifu.y, 32'd0);
      chk("rst_ir", {31'd0, ifs.in_ready}, 32'd1);
`ifdef FCVTSW_FLAGS_EN
      chk("rst_nx", {31'd0, ifs.nx}, 32'd0);
`endif
      @(negedge clk);
      rstn = 1'b1;

      // latency: x=0 accepted, result visible exactly three cycles later
      step(1'b1, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0, acc);
      chk("lat_acc", {31'd0, acc}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, acc);
         chk("lat_ov", {31'd0, ifs.out_valid}, (k == 3) ? 32'd1 : 32'd0);
      end
      drain("lat");

      // directed values, streamed back to back
      for (int i = 0; i < 8; i++) begin
         step(1'b1, dir_x[i], 1'b1, 1'b1, dir_ys[i], dir_yu[i], acc);
         chk("dir_acc", {31'd0, acc}, 32'd1);
      end
      drain("dir");

      // backpressure: 1..5 streamed, consumer stalls 4 cycles from first out_valid
      idx = 0;
      for (int c = 0; c < 40 && (idx < 5 || q_ys.size() != 0); c++) begin
         ordy = !(c >= 3 && c <= 6);
         step(idx < 5, 32'(idx + 1), ordy, 1'b1, bp_y[(idx < 5) ? idx : 0],
              bp_y[(idx < 5) ? idx : 0], acc);
         if (c >= 3 && c <= 6) begin
            chk("bp_ov", {31'd0, ifs.out_valid}, 32'd1);
            chk("bp_ir", {31'd0, ifs.in_ready}, 32'd0);
            chk("bp_y", ifs.y, 32'h3F800000);
         end
         if (acc) idx++;
      end
      chk("bp_count", 32'(idx), 32'd5);
      drain("bp");

      // randomized traffic with random bubbles and backpressure
      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0: xv = r;
            1: xv = r >> $urandom_range(0, 31);
            2: xv = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
            default: xv = 32'd0 - (r >> $urandom_range(0, 31));
         endcase
         step($urandom_range(0, 3) != 0, xv, $urandom_range(0, 3) != 0, 1'b0, 32'd0, 32'd0, acc);
      end
      drain("rnd");

      // reset with three conversions in flight
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'(i + 7), 1'b1, 1'b0, 32'd0, 32'd0, acc);
         chk("mr_acc", {31'd0, acc}, 32'd1);
      end
      @(negedge clk);
      rstn = 1'b0;
      set_inputs(1'b0, 32'd0, 1'b1);
      #1;
      chk("mr_ov_s", {31'd0, ifs.out_valid}, 32'd0);
      chk("mr_ov_u", {31'd0, ifu.out_valid}, 32'd0);
      chk("mr_y", ifs.y, 32'd0);
      q_ys.delete();
      q_yu.delete();
      q_nxs.delete();
      q_nxu.delete();
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("mr_ir", {31'd0, ifs.in_ready}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, acc);
         chk("mr_stale_s", {31'd0, ifs.out_valid}, 32'd0);
         chk("mr_stale_u", {31'd0, ifu.out_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
